// File: rtl/sd_sector_responder.sv
// Sector-request responder serving 512-byte sectors from an internal store.
// Optional mount event and image ports: define SD_MOUNT_EN.
module sd_sector_responder #(
  parameter int LBA_BITS  = 7,
  parameter int ACK_DELAY = 4,
  parameter int WORD_GAP  = 0
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [31:0] sd_lba,
  input  logic        sd_rd,
  input  logic        sd_wr,
  output logic        sd_ack,
  output logic [7:0]  sd_buff_addr,
  output logic [15:0] sd_buff_dout,
  input  logic [15:0] sd_buff_din,
  output logic        sd_buff_wr,
  output logic        busy,
  output logic        lba_err
`ifdef SD_MOUNT_EN
  ,
  output logic        img_mounted,
  output logic        img_readonly,
  output logic [63:0] img_size
`endif
);

  localparam int CW = 16;
  localparam int AW = LBA_BITS + 8;
  localparam int DEPTH = 1 << AW;
  localparam bit HAS_GAP = (WORD_GAP > 0);
  localparam logic [CW-1:0] ACK_LAST = CW'(ACK_DELAY - 1);
  localparam logic [CW-1:0] GAP_LAST =
    CW'(HAS_GAP ? WORD_GAP - 1 : 0);

  typedef enum logic [2:0] {
    IDLE, WAIT, XA, XB, XG, DONE
  } state_t;

  state_t state, state_d;

  logic [CW-1:0]       cnt;
  logic                dir_rd;
  logic                lba_ok;
  logic [LBA_BITS-1:0] lba_q;
  logic [7:0]          word;
  logic                req;
  logic                lba_oor;
  logic                last_word;
  logic                ram_re;
  logic                ram_we;
  logic [AW-1:0]       ram_addr;
  logic [15:0]         dout_q;
  logic [15:0]         mem [DEPTH];

  assign req       = sd_rd | sd_wr;
  assign lba_oor   = |sd_lba[31:LBA_BITS];
  assign last_word = (word == 8'hFF);
  assign ram_addr  = {lba_q, word};

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      word    <= '0;
      dir_rd  <= 1'b0;
      lba_q   <= '0;
      lba_ok  <= 1'b0;
      lba_err <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= (state_d != state) ? '0 : cnt + 1'b1;
      if (state == IDLE && req) begin
        dir_rd <= sd_rd;
        lba_q  <= sd_lba[LBA_BITS-1:0];
        lba_ok <= ~lba_oor;
        if (lba_oor) lba_err <= 1'b1;
      end
      // Word index moves only on phase A entry, so it holds 255 past DONE
      if (state_d == XA)
        word <= (state == WAIT) ? 8'd0 : word + 8'd1;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: if (req) state_d = WAIT;
      WAIT: if (cnt == ACK_LAST) state_d = XA;
      XA:   state_d = XB;
      XB: begin
        if (HAS_GAP)        state_d = XG;
        else if (last_word) state_d = DONE;
        else                state_d = XA;
      end
      XG: if (cnt == GAP_LAST)
            state_d = last_word ? DONE : XA;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sd_ack     = (state == XA) || (state == XB) || (state == XG);
    busy       = (state != IDLE);
    sd_buff_wr = (state == XB) && dir_rd;
    ram_re     = (state == XA) && dir_rd;
    ram_we     = (state == XB) && !dir_rd && lba_ok;
  end

  assign sd_buff_addr = word;
  assign sd_buff_dout = dout_q;

  always_ff @(posedge clk_sys) begin
    if (ram_we) mem[ram_addr] <= sd_buff_din;
  end

  // Out-of-range sectors read back as zero
  always_ff @(posedge clk_sys) begin
    if (reset)       dout_q <= '0;
    else if (ram_re) dout_q <= lba_ok ? mem[ram_addr] : 16'h0000;
  end

`ifdef SD_MOUNT_EN
  logic [4:0] mnt_cnt;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mnt_cnt     <= '0;
      img_mounted <= 1'b0;
    end else begin
      if (mnt_cnt != 5'd16) mnt_cnt <= mnt_cnt + 5'd1;
      img_mounted <= (mnt_cnt == 5'd15);
    end
  end

  assign img_readonly = 1'b0;
  assign img_size     = 64'd512 << LBA_BITS;
`endif

endmodule
